calc_sequencer: RTL
===================

# calc_sequencer

Multi-cycle fetch/decode/execute controller for the limited-function calculator datapath. It owns the program counter, the instruction register and the loop counter. It drives the instruction-memory address, the adder/subtractor sign control, the novel-operation mux select and the accumulator write enable, so a program runs from `start` to a HALT instruction. It sits between the instruction memory and the decoder/adder/accumulator, and replaces the free-running PC adder and the always-enabled accumulator write.

## Interface
Parameters:
- `PC_W`, 8, program counter / instruction address width
- `CNT_W`, 14, loop counter width (matches the immB field)

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle request to run the program from address 0
- `imem_addr`  out  PC_W  instruction memory address; memory returns data one cycle later
- `imem_data`  in  32  instruction word from memory
- `instr`  out  32  instruction register, fed to the decoder
- `sign_ctrl`  out  1  1 = subtract, 0 = add
- `store_prev_ctrl`  out  1  mux select: 0 = accumulator, 1 = immB
- `acc_we`  out  1  accumulator write enable, one-cycle pulse
- `add_overflow`  in  1  overflow flag from the adder/subtractor
- `busy`  out  1  high from the cycle after an accepted `start` until DONE is left
- `done`  out  1  one-cycle pulse when the program ends
- `trap`  out  1  sticky overflow trap flag (see Configuration)
- `pc`  out  PC_W  current program counter, for debug

## Operation
- Instruction fields:
  - funct = `instr[31:29]`
  - immA = `instr[27:14]`
  - immB = `instr[13:0]`
- Funct codes:
  - ADD 000: acc = immA + immB
  - SUB 001: acc = immA − immB
  - ACCADD 010: acc = immA + acc
  - ACCSUB 011: acc = immA − acc
  - NOP 100
  - SETCNT 101: cnt = immB
  - LOOP 110: if cnt ≠ 0 then cnt−1 and pc = immA[PC_W-1:0], else fall through
  - HALT 111
- States: IDLE, FETCH, DECODE, EXEC, DONE.
- IDLE: `start`=1 → pc=0, cnt=0, clear `trap`, go to FETCH. Otherwise stay in IDLE.
- FETCH: `imem_addr`=pc; go to DECODE.
- DECODE: `instr` ← `imem_data`; go to EXEC.
- EXEC: drive the controls combinationally from `instr`.
  - `sign_ctrl` = funct[0] for funct 000–011, else 0.
  - `store_prev_ctrl` = 1 for ADD/SUB, 0 otherwise.
  - `acc_we`=1 for the arithmetic codes only.
  - pc ← pc+1, or the LOOP target.
  - Go to FETCH, or to DONE on HALT.
- DONE: `done`=1 for one cycle, then IDLE.
- PC arithmetic is modulo 2^PC_W: incrementing from 2^PC_W−1 gives 0.
- LOOP with cnt=0 falls through, and cnt stays 0 (no underflow).
- `start` is ignored whenever state ≠ IDLE, including in DONE.
- Reset, asynchronous and at any point: state=IDLE, pc=0, cnt=0, `instr`=0. All outputs are 0, including `acc_we`, `busy`, `done` and `trap`.

## Timing
- Every instruction takes 3 cycles (FETCH, DECODE, EXEC).
- `acc_we` is high only in EXEC. The accumulator captures on the clock edge that ends EXEC.
- `start` sampled high in IDLE → first FETCH on the next cycle, and `busy` rises with it.
- HALT in EXEC → `done` in the next cycle, IDLE the cycle after, `busy` low in IDLE.
- A program of N instructions ending in HALT: `done` asserts 3N+1 cycles after the `start` edge.

## Configuration
- With `CALC_SEQ_OVF_TRAP_EN` defined:
  - `add_overflow`=1 in EXEC of an arithmetic op suppresses `acc_we` and sets `trap`.
  - The FSM goes directly to DONE, and pc is not advanced.
  - `trap` holds until the next accepted `start` or reset.
- Undefined: `add_overflow` is ignored, `trap` is tied 0, and overflowing results are written.

## Structure
- Shared package `calc_pkg`:
  - funct code constants
  - state enum
  - instruction field bit positions
- Sub-module `calc_seq_ctrl_dec`: combinational funct → {`sign_ctrl`, `store_prev_ctrl`, `acc_we_raw`, is_loop, is_setcnt, is_halt}.
- FSM, PC and loop counter stay in the top module.

## Test plan
- Reset mid-EXEC of an ADD (`acc_we`=1) → all outputs 0 immediately, IDLE, pc=0.
- Program {ADD 5,3; HALT}, `start` pulse → exactly one `acc_we` with `sign_ctrl`=0 and `store_prev_ctrl`=1; `done` 7 cycles after `start`.
- {SUB 2,7; ACCSUB 10; HALT} → `sign_ctrl`=1 on both ops; `store_prev_ctrl` 1 then 0; accumulator ends at 10−(−5)=15.
- {SETCNT 3; ACCADD 1; LOOP →1; HALT} → 4 `acc_we` pulses; cnt reads 0 at HALT.
- `start` asserted while busy, and again in DONE → ignored; a second `start` in IDLE reruns the program from pc=0.
- With `CALC_SEQ_OVF_TRAP_EN` defined, force `add_overflow`=1 on the 2nd ADD → no `acc_we` for it; `trap`=1 and `done` the next cycle; `trap` clears on the next `start`.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg
//   Shared definitions for the calculator sequencer: funct codes, the
//   sequencer state encoding and the instruction field positions.
//   Instruction layout: [31:29] funct, [28] unused, [27:14] immA, [13:0] immB.
package calc_pkg;

  localparam logic [2:0] FUNCT_ADD    = 3'b000;
  localparam logic [2:0] FUNCT_SUB    = 3'b001;
  localparam logic [2:0] FUNCT_ACCADD = 3'b010;
  localparam logic [2:0] FUNCT_ACCSUB = 3'b011;
  localparam logic [2:0] FUNCT_NOP    = 3'b100;
  localparam logic [2:0] FUNCT_SETCNT = 3'b101;
  localparam logic [2:0] FUNCT_LOOP   = 3'b110;
  localparam logic [2:0] FUNCT_HALT   = 3'b111;

  localparam int FUNCT_MSB = 31;
  localparam int FUNCT_LSB = 29;
  localparam int IMMA_MSB  = 27;
  localparam int IMMA_LSB  = 14;
  localparam int IMMB_MSB  = 13;
  localparam int IMMB_LSB  = 0;
  localparam int IMM_W     = 14;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic logic [2:0] funct_of(input logic [31:0] word);
    return word[FUNCT_MSB:FUNCT_LSB];
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if
//   Bundles the sequencer's instruction-memory bus, datapath controls and
//   status signals.
//   master : the sequencer (drives address, instr, controls, status)
//   slave  : memory/datapath/host side (drives start, imem_data, add_overflow)
interface calc_sequencer_if #(
  parameter int PC_W = 8
);
  logic            start;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_data;
  logic [31:0]     instr;
  logic            sign_ctrl;
  logic            store_prev_ctrl;
  logic            acc_we;
  logic            add_overflow;
  logic            busy;
  logic            done;
  logic            trap;
  logic [PC_W-1:0] pc;

  modport master (
    input  start, imem_data, add_overflow,
    output imem_addr, instr, sign_ctrl, store_prev_ctrl, acc_we,
           busy, done, trap, pc
  );

  modport slave (
    output start, imem_data, add_overflow,
    input  imem_addr, instr, sign_ctrl, store_prev_ctrl, acc_we,
           busy, done, trap, pc
  );
endinterface

// File: rtl/calc_seq_ctrl_dec.sv
// calc_seq_ctrl_dec
//   Purely combinational funct decoder for the sequencer.
//   Ports:
//     funct           in  3  instruction funct field
//     sign_ctrl       out 1  1 = subtract (SUB, ACCSUB)
//     store_prev_ctrl out 1  1 = second operand is immB (ADD, SUB)
//     acc_we_raw      out 1  arithmetic op, before state/overflow gating
//     is_loop         out 1  LOOP
//     is_setcnt       out 1  SETCNT
//     is_halt         out 1  HALT
module calc_seq_ctrl_dec
  import calc_pkg::*;
(
  input  logic [2:0] funct,
  output logic       sign_ctrl,
  output logic       store_prev_ctrl,
  output logic       acc_we_raw,
  output logic       is_loop,
  output logic       is_setcnt,
  output logic       is_halt
);

  always_comb begin
    sign_ctrl       = 1'b0;
    store_prev_ctrl = 1'b0;
    acc_we_raw      = 1'b0;
    is_loop         = 1'b0;
    is_setcnt       = 1'b0;
    is_halt         = 1'b0;
    case (funct)
      FUNCT_ADD: begin
        store_prev_ctrl = 1'b1;
        acc_we_raw      = 1'b1;
      end
      FUNCT_SUB: begin
        sign_ctrl       = 1'b1;
        store_prev_ctrl = 1'b1;
        acc_we_raw      = 1'b1;
      end
      FUNCT_ACCADD: begin
        acc_we_raw = 1'b1;
      end
      FUNCT_ACCSUB: begin
        sign_ctrl  = 1'b1;
        acc_we_raw = 1'b1;
      end
      FUNCT_SETCNT: is_setcnt = 1'b1;
      FUNCT_LOOP:   is_loop   = 1'b1;
      FUNCT_HALT:   is_halt   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer
//   Fetch/decode/execute controller for the calculator datapath. Owns the
//   program counter, instruction register and loop counter; each
//   instruction takes FETCH, DECODE and EXEC (3 cycles).
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for start; start clears pc, cnt and trap
//   FETCH  | imem_addr = pc presented to memory
//   DECODE | instruction register loads imem_data
//   EXEC   | controls driven from instr; pc/cnt updated
//   DONE   | done pulse for one cycle, back to IDLE
//
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset
//     bus    calc_sequencer_if.master: start, imem_addr/imem_data, instr,
//            sign_ctrl, store_prev_ctrl, acc_we, add_overflow, busy,
//            done, trap, pc
//
//   Optional build macro CALC_SEQ_OVF_TRAP_EN: an arithmetic op that
//   overflows suppresses its accumulator write, sets the sticky trap flag
//   and ends the program without advancing pc. Without it add_overflow is
//   ignored and trap stays 0.
//
//   PC_W must not exceed the 14-bit immA field; CNT_W must not exceed immB.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  calc_sequencer_if.master bus
);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       instr_q, instr_d;
  logic              trap_q, trap_d;

  logic dec_sign, dec_store_prev, dec_acc_we;
  logic dec_loop, dec_setcnt, dec_halt;
  logic in_exec;
  logic ovf_hit;

  calc_seq_ctrl_dec u_dec (
    .funct           (funct_of(instr_q)),
    .sign_ctrl       (dec_sign),
    .store_prev_ctrl (dec_store_prev),
    .acc_we_raw      (dec_acc_we),
    .is_loop         (dec_loop),
    .is_setcnt       (dec_setcnt),
    .is_halt         (dec_halt)
  );

  assign in_exec = (state_q == S_EXEC);

`ifdef CALC_SEQ_OVF_TRAP_EN
  assign ovf_hit = in_exec && dec_acc_we && bus.add_overflow;
`else
  assign ovf_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      instr_q <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      trap_q  <= trap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    trap_d  = trap_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pc_d    = '0;
          cnt_d   = '0;
          trap_d  = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        instr_d = bus.imem_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (ovf_hit) begin
          // pc stays on the faulting instruction for debug
          trap_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          pc_d = pc_q + PC_W'(1);
          if (dec_loop && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
            pc_d  = instr_q[IMMA_LSB +: PC_W];
          end
          if (dec_setcnt) begin
            cnt_d = instr_q[IMMB_LSB +: CNT_W];
          end
          state_d = dec_halt ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.imem_addr       = pc_q;
  assign bus.pc              = pc_q;
  assign bus.instr           = instr_q;
  assign bus.sign_ctrl       = in_exec & dec_sign;
  assign bus.store_prev_ctrl = in_exec & dec_store_prev;
  assign bus.acc_we          = in_exec & dec_acc_we & ~ovf_hit;
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.done            = (state_q == S_DONE);
  assign bus.trap            = trap_q;

endmodule
